// File: rtl/elevator_dispatch.sv
// rtl/elevator_dispatch.sv - LOOK-policy car controller answering per-floor call flags
module elevator_dispatch #(
    parameter int  FLOORS      = 4,
    parameter int  FLOOR_TICKS = 50_000_000,
    parameter int  DOOR_TICKS  = 100_000_000,
    localparam int FW          = (FLOORS > 1) ? $clog2(FLOORS) : 1,
    localparam int TW          = $clog2(FLOOR_TICKS),
    localparam int DW          = $clog2(DOOR_TICKS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [FLOORS-1:0] i_call_req,
    output logic [FLOORS-1:0] o_call_ack,
    output logic [FW-1:0]     o_cur_floor,
    output logic              o_dir_up,
    output logic              o_moving,
    output logic              o_door_open
);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    localparam logic [FLOORS-1:0] ACK_BIT0 = FLOORS'(1);

    state_t            r_state, w_state_next;
    logic [FW-1:0]     r_cur_floor, w_floor_next, w_nf;
    logic              r_dir_up, w_dir_next;
    logic [TW-1:0]     r_tick, w_tick_next;
    logic [DW-1:0]     r_door_cnt, w_door_next;
    logic [1:0]        r_guard, w_guard_next;
    logic [FLOORS-1:0] r_call_ack, w_ack_next, w_eff_req;
    logic              w_here, w_above, w_below, w_above_nf, w_below_nf, w_ahead_nf;

    // The call block needs two cycles to drop its flag after an ack; hide it meanwhile.
    always_comb begin
        w_eff_req = i_call_req;
        if (r_guard != 2'd0) begin
            w_eff_req[r_cur_floor] = 1'b0;
        end
    end

    assign w_here = w_eff_req[r_cur_floor];
    assign w_nf   = r_dir_up ? r_cur_floor + FW'(1) : r_cur_floor - FW'(1);

    always_comb begin
        w_above    = 1'b0;
        w_below    = 1'b0;
        w_above_nf = 1'b0;
        w_below_nf = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (w_eff_req[i]) begin
                if (FW'(i) > r_cur_floor) w_above    = 1'b1;
                if (FW'(i) < r_cur_floor) w_below    = 1'b1;
                if (FW'(i) > w_nf)        w_above_nf = 1'b1;
                if (FW'(i) < w_nf)        w_below_nf = 1'b1;
            end
        end
    end

    assign w_ahead_nf = r_dir_up ? w_above_nf : w_below_nf;

    always_comb begin
        w_state_next = r_state;
        w_floor_next = r_cur_floor;
        w_dir_next   = r_dir_up;
        w_tick_next  = r_tick;
        w_door_next  = r_door_cnt;
        w_ack_next   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_here) begin
                    w_state_next = S_DOOR;
                    w_ack_next   = ACK_BIT0 << r_cur_floor;
                    w_door_next  = '0;
                end else if (w_above && (r_dir_up || !w_below)) begin
                    w_dir_next   = 1'b1;
                    w_state_next = S_MOVE;
                    w_tick_next  = '0;
                end else if (w_below) begin
                    w_dir_next   = 1'b0;
                    w_state_next = S_MOVE;
                    w_tick_next  = '0;
                end
            end
            S_MOVE: begin
                if (r_tick == TW'(FLOOR_TICKS - 1)) begin
                    w_tick_next  = '0;
                    w_floor_next = w_nf;
                    if (w_eff_req[w_nf]) begin
                        w_state_next = S_DOOR;
                        w_ack_next   = ACK_BIT0 << w_nf;
                        w_door_next  = '0;
                    end else if (!w_ahead_nf) begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_tick_next = r_tick + TW'(1);
                end
            end
            S_DOOR: begin
                // A fresh press at this floor holds the door and is acknowledged again.
                if (w_here) begin
                    w_ack_next  = ACK_BIT0 << r_cur_floor;
                    w_door_next = '0;
                end else if (r_door_cnt == DW'(DOOR_TICKS - 1)) begin
                    w_state_next = S_IDLE;
                    w_door_next  = '0;
                end else begin
                    w_door_next = r_door_cnt + DW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_ack_next != '0) begin
            w_guard_next = 2'd2;
        end else if (r_guard != 2'd0) begin
            w_guard_next = r_guard - 2'd1;
        end else begin
            w_guard_next = 2'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cur_floor <= '0;
            r_dir_up    <= 1'b1;
            r_tick      <= '0;
            r_door_cnt  <= '0;
            r_guard     <= 2'd0;
            r_call_ack  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cur_floor <= w_floor_next;
            r_dir_up    <= w_dir_next;
            r_tick      <= w_tick_next;
            r_door_cnt  <= w_door_next;
            r_guard     <= w_guard_next;
            r_call_ack  <= w_ack_next;
        end
    end

    assign o_call_ack  = r_call_ack;
    assign o_cur_floor = r_cur_floor;
    assign o_dir_up    = r_dir_up;
    assign o_moving    = (r_state == S_MOVE);
    assign o_door_open = (r_state == S_DOOR);

endmodule

// File: tb/tb_elevator_dispatch.sv
// tb/tb_elevator_dispatch.sv - self-checking bench for elevator_dispatch
module tb_elevator_dispatch;
    localparam int FLOORS = 4;
    localparam int FT     = 4;
    localparam int DT     = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] call_req;
    logic [3:0] call_ack;
    logic [1:0] cur_floor;
    logic       dir_up, moving, door_open;

    always #5 clk = ~clk;

    elevator_dispatch #(.FLOORS(FLOORS), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_call_req (call_req),
        .o_call_ack (call_ack),
        .o_cur_floor(cur_floor),
        .o_dir_up   (dir_up),
        .o_moving   (moving),
        .o_door_open(door_open)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] prev_ack;

    // Car model: mode 0 idle, 1 travelling, 2 door open; m_left counts cycles down to the next event.
    int m_mode, m_floor, m_left, m_guard, m_ack;
    bit m_up;

    typedef struct {
        logic [3:0] press;
        logic [3:0] ack;
        int         floor;
        bit         mv;
        bit         door;
        bit         up;
    } vec_t;
    vec_t tbl[20];

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pack_dut();
        return int'({call_ack, cur_floor, dir_up, moving, door_open});
    endfunction

    function automatic int pack_model();
        logic [3:0] a;
        a = (m_ack >= 0) ? 4'(1 << m_ack) : 4'd0;
        return int'({a, 2'(m_floor), m_up, m_mode == 1, m_mode == 2});
    endfunction

    function automatic int pack_exp(logic [3:0] a, int f, bit up, bit mv, bit dr);
        return int'({a, 2'(f), up, mv, dr});
    endfunction

    task automatic model_reset();
        m_mode = 0; m_floor = 0; m_left = 0; m_guard = 0; m_ack = -1; m_up = 1'b1;
    endtask

    function automatic bit any_dir(logic [3:0] v, int f, bit up);
        for (int i = 0; i < FLOORS; i++)
            if (v[i] && (up ? (i > f) : (i < f))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(logic [3:0] req, logic rst);
        logic [3:0] eff;
        int ack;
        if (!rst) begin
            model_reset();
            return;
        end
        eff = req;
        if (m_guard > 0) eff[m_floor] = 1'b0;
        ack = -1;
        case (m_mode)
            0: begin
                if (eff[m_floor]) begin
                    m_mode = 2; m_left = DT; ack = m_floor;
                end else if (any_dir(eff, m_floor, 1'b1) && (m_up || !any_dir(eff, m_floor, 1'b0))) begin
                    m_up = 1'b1; m_mode = 1; m_left = FT;
                end else if (any_dir(eff, m_floor, 1'b0)) begin
                    m_up = 1'b0; m_mode = 1; m_left = FT;
                end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor += m_up ? 1 : -1;
                    if (eff[m_floor]) begin
                        m_mode = 2; m_left = DT; ack = m_floor;
                    end else if (any_dir(eff, m_floor, m_up)) begin
                        m_left = FT;
                    end else begin
                        m_mode = 0;
                    end
                end
            end
            default: begin
                if (eff[m_floor]) begin
                    ack = m_floor; m_left = DT;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
        endcase
        m_guard = (ack >= 0) ? 2 : ((m_guard > 0) ? m_guard - 1 : 0);
        m_ack   = ack;
    endtask

    // One clock: model sees what the DUT sampled; call blocks toggle one cycle after an ack.
    task automatic step();
        logic [3:0] req_s;
        logic       rst_s;
        req_s = call_req;
        rst_s = rst_n;
        @(posedge clk);
        model_edge(req_s, rst_s);
        #1;
        call_req = call_req ^ prev_ack;
        prev_ack = call_ack;
        check("model", pack_dut(), pack_model());
    endtask

    function automatic int ack_floor(logic [3:0] a);
        for (int i = 0; i < FLOORS; i++) if (a[i]) return i;
        return -1;
    endfunction

    initial begin
        int q[$];
        int dir_at_last, door_cnt, ack_cnt, f;
        bit added;

        for (int i = 0; i < 20; i++) begin
            tbl[i].press = (i == 0) ? 4'b1000 : 4'b0000;
            tbl[i].floor = (i < 4) ? 0 : (i < 8) ? 1 : (i < 12) ? 2 : 3;
            tbl[i].mv    = (i < 12);
            tbl[i].door  = (i >= 12 && i < 18);
            tbl[i].ack   = (i == 12) ? 4'b1000 : 4'b0000;
            tbl[i].up    = 1'b1;
        end

        // Reset held with calls pending, then LOOK order 1,3 and a late call at 0.
        rst_n = 1'b0; call_req = 4'b1010; prev_ack = 4'b0; model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_hold%0d", i), pack_dut(), pack_exp(4'b0, 0, 1'b1, 1'b0, 1'b0));
        end
        rst_n = 1'b1;
        step();
        check("depart_up", pack_dut(), pack_exp(4'b0, 0, 1'b1, 1'b1, 1'b0));
        added = 1'b0; dir_at_last = -1;
        for (int c = 0; c < 150 && q.size() < 3; c++) begin
            step();
            if (call_ack != 4'b0) begin
                q.push_back(ack_floor(call_ack));
                dir_at_last = int'(dir_up);
            end
            if (!added && cur_floor == 2'd1 && door_open) begin
                call_req = call_req | 4'b0001;
                added = 1'b1;
            end
        end
        check("order_count", q.size(), 3);
        if (q.size() == 3) begin
            check("order0", q[0], 1);
            check("order1", q[1], 3);
            check("order2", q[2], 0);
            check("dir_down_at_0", dir_at_last, 0);
        end
        repeat (10) step();

        // Call at the idle floor: single ack, door open exactly DT cycles.
        call_req = call_req | 4'b0001;
        step();
        check("here_ack", pack_dut(), pack_exp(4'b0001, 0, 1'b0, 1'b0, 1'b1));
        door_cnt = 1; ack_cnt = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            door_cnt += int'(door_open);
            ack_cnt  += int'(call_ack != 4'b0);
        end
        check("here_door_len", door_cnt, DT);
        check("here_ack_cnt", ack_cnt, 1);
        check("here_cleared", int'(call_req[0]), 0);

        // Table: floor 0 to floor 3.
        for (int i = 0; i < 20; i++) begin
            call_req = call_req | tbl[i].press;
            step();
            check($sformatf("tbl%0d", i), pack_dut(),
                  pack_exp(tbl[i].ack, tbl[i].floor, tbl[i].up, tbl[i].mv, tbl[i].door));
        end

        // Asynchronous reset in the middle of a trip.
        call_req = call_req | 4'b0001;
        repeat (6) step();
        check("pre_rst_moving", int'(moving), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", pack_dut(), pack_exp(4'b0, 0, 1'b1, 1'b0, 1'b0));
        model_reset(); call_req = 4'b0; prev_ack = 4'b0;
        step();
        rst_n = 1'b1;

        // Call 2 cancelled en route: stop at floor 1 without ack.
        call_req = 4'b0100;
        step();
        step();
        call_req[2] = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            ack_cnt += int'(call_ack != 4'b0);
        end
        check("cancel_stop", pack_dut(), pack_exp(4'b0, 1, 1'b1, 1'b0, 1'b0));
        repeat (2) step();
        check("cancel_idle", pack_dut(), pack_exp(4'b0, 1, 1'b1, 1'b0, 1'b0));
        check("cancel_no_ack", ack_cnt, 0);

        // Door hold: call re-pressed at door cycle 4 at floor 2.
        call_req = call_req | 4'b0100;
        repeat (5) step();
        check("hold_first_ack", pack_dut(), pack_exp(4'b0100, 2, 1'b1, 1'b0, 1'b1));
        door_cnt = 1;
        repeat (3) begin step(); door_cnt += int'(door_open); end
        call_req = call_req | 4'b0100;
        step();
        door_cnt += int'(door_open);
        check("hold_second_ack", int'(call_ack), 4);
        repeat (8) begin step(); door_cnt += int'(door_open); end
        check("hold_door_len", door_cnt, 4 + DT);
        check("hold_cleared", int'(call_req[2]), 0);

        // Random presses and cancellations against the model.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(7) == 0) call_req[$urandom_range(3)] = 1'b1;
            if ($urandom_range(39) == 0) call_req[$urandom_range(3)] = 1'b0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/elevator_dispatch.md
# elevator_dispatch

Car-side responder for the per-floor hall/cabin call buttons. Each call button block holds a toggling pending flag; this block samples all flags, moves a modelled car floor by floor using a LOOK policy, opens the door at requested floors, and returns a one-cycle acknowledge pulse per floor. That pulse is wired to the matching call block's press input, toggling its flag back to idle. It sits between the call-button array and the floor display/door indicator logic.

## Interface
- FLOORS, 4: number of floors (2..16).
- FLOOR_TICKS, 50_000_000: clock cycles to travel one floor (≥2).
- DOOR_TICKS, 100_000_000: clock cycles the door stays open (≥4).
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- call_req  input  FLOORS  level; bit i high = floor i call pending.
- call_ack  output  FLOORS  one-cycle pulse; bit i served (drives call i press input).
- cur_floor  output  FW  current car floor, FW = max(1, $clog2(FLOORS)).
- dir_up  output  1  travel direction: 1 up, 0 down.
- moving  output  1  high in MOVE state.
- door_open  output  1  high in DOOR state.

## Operation
- Reset values: state IDLE, cur_floor 0, dir_up 1, moving 0, door_open 0, call_ack 0, all counters 0.
- eff_req = call_req with bit cur_floor forced 0 while guard counter nonzero; guard loaded to 2 on every ack (absorbs call-block toggle latency).
- above = any eff_req bit > cur_floor; below = any eff_req bit < cur_floor; here = eff_req[cur_floor].
- IDLE: here → DOOR, pulse call_ack[cur_floor]. Else if (dir_up & above) or (!dir_up & !below & above) → dir_up=1, MOVE. Else if below → dir_up=0, MOVE. Else stay.
- MOVE: tick counter 0..FLOOR_TICKS-1; at terminal count cur_floor ±1 (per dir_up), counter clears. At that edge, with nf = new floor: eff_req[nf] → DOOR + call_ack[nf]; else requests still ahead in dir_up → stay MOVE; else → IDLE.
- DOOR: door counter 0..DOOR_TICKS-1, then IDLE. If here rises again during DOOR (guard expired), re-pulse call_ack[cur_floor] and restart door counter (door hold).
- Direction retained across IDLE; reversal only when nothing remains ahead.
- cur_floor never leaves 0..FLOORS-1; requests ahead are impossible at end floors, so no wrap.
- call_ack is one-hot or zero; never two bits in one cycle.
- Call cancelled (call_req bit dropped) while car en route: no stop there; re-evaluated at each floor arrival.

## Timing
- All outputs registered; call_ack, door_open and cur_floor update on the same edge.
- IDLE with here: call_ack/door_open high 1 cycle after call_req first sampled high.
- IDLE to departure: 1 cycle decision, then FLOOR_TICKS cycles per floor; n-floor trip = 1 + n·FLOOR_TICKS cycles from sampled request to ack.
- door_open high exactly DOOR_TICKS cycles (absent hold), then 1 IDLE cycle before next move.
- Simultaneous here and remote request: here served first.
- Reset asserted mid-move or mid-door: immediate return to reset values; car modelled at floor 0; no ack issued.

## Test plan
(FLOORS=4, FLOOR_TICKS=4, DOOR_TICKS=6, call model toggles on ack.)
- Reset with call_req=4'b1010 held → all outputs at reset values while rst_n=0; after release, car departs up 1 cycle later.
- Idle at floor 0, call_req[0] set → call_ack=4'b0001 for 1 cycle next edge, door_open high 6 cycles, call_req[0] cleared, no second ack.
- From floor 0, call_req[3] set → moving, cur_floor 1,2,3 at 4-cycle intervals, call_ack[3] 13 cycles after request.
- Heading up from 0 with calls 1 and 3, call 0 added at floor 1 → service order 1, 3, then dir_up=0 and 0; ack pulses in that order.
- Call 2 set then cleared while car between 0 and 1 → car stops at floor 1 into IDLE, no ack, moving=0.
- Call re-asserted at floor 2 at door-open cycle 4 → second call_ack[2], door_open total 4+6 cycles.
